// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD/binary converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_BCD2BIN = 1'b0;
  localparam logic MODE_BIN2BCD = 1'b1;

  // 10**n, used to derive the largest operand representable in DIGITS digits.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit corrector: -3 for digits >= 8 when decoding, +3 for digits >= 5 when encoding.
module bcd_digit_adj
  import bcd_conv_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       mode_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (mode_i == MODE_BCD2BIN) begin
      if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
    end else begin
      if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_bin_conv_seq.sv
// Bit-serial bidirectional BCD<->binary converter with valid/ready on both sides
// and an SN184-style active-low enable that blanks the output to all ones.
module bcd_bin_conv_seq
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  g_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int EW = (DW > BIN_W) ? DW : BIN_W;
  localparam logic [BIN_W-1:0] LIMIT = BIN_W'(pow10(DIGITS) - 1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d;

  logic [EW-1:0]     din_ext;
  logic              bcd_bad, bin_bad, operand_bad;
  logic [DW-1:0]     bcd_shr, adj_in, adj_out;
  logic [DW-1:0]     step_bcd;
  logic [BIN_W-1:0]  step_bin;
  logic [DW-1:0]     result;

  assign din_ext = EW'(din);

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (din[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  assign bin_bad     = ((din_ext >> BIN_W) != '0) || (din_ext[BIN_W-1:0] > LIMIT);
  assign operand_bad = (mode == MODE_BCD2BIN) ? bcd_bad : bin_bad;

  // Decoding corrects after the right shift, encoding corrects before the left shift.
  assign bcd_shr = {1'b0, bcd_q[DW-1:1]};
  assign adj_in  = (mode_q == MODE_BIN2BCD) ? bcd_q : bcd_shr;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (adj_in[4*g +: 4]),
      .mode_i  (mode_q),
      .digit_o (adj_out[4*g +: 4])
    );
  end

  always_comb begin
    if (mode_q == MODE_BCD2BIN) begin
      step_bcd = adj_out;
      step_bin = {bcd_q[0], bin_q[BIN_W-1:1]};
    end else begin
      step_bcd = {adj_out[DW-2:0], bin_q[BIN_W-1]};
      step_bin = {bin_q[BIN_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mode_d = mode;
          cnt_d  = '0;
          if (mode == MODE_BCD2BIN) begin
            bcd_d = din;
            bin_d = '0;
          end else begin
            bcd_d = '0;
            bin_d = din_ext[BIN_W-1:0];
          end
          err_d   = operand_bad;
          state_d = operand_bad ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        bcd_d = step_bcd;
        bin_d = step_bin;
        if (cnt_q == CW'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_BCD2BIN;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
    end
  end

  assign result    = (mode_q == MODE_BIN2BCD) ? bcd_q : DW'(bin_q);
  assign in_ready  = (state_q == IDLE) && !g_n;
  assign out_valid = (state_q == DONE) && !g_n;
  assign err       = out_valid && err_q;
  assign dout      = (out_valid && !err_q) ? result : '1;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_bin_conv_seq.sv
// Scoreboard bench for bcd_bin_conv_seq (DIGITS=2, BIN_W=7) with an arithmetic reference model.
module tb_bcd_bin_conv_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int DW     = 4 * DIGITS;
  localparam int W      = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          g_n = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] din = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dout;
  logic          err;
  logic [1:0]    state_dbg;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            prev_acc = 0;
  int            lat;
  bit            rnd_en = 1'b0;

  bcd_bin_conv_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g_n       (g_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: {err, dout} from decimal arithmetic.
  function automatic logic [W-1:0] ref_model(input logic m, input logic [DW-1:0] d);
    int v;
    bit bad;
    logic [3:0] nib;
    logic [DW-1:0] r;
    bad = 1'b0;
    r = '0;
    if (m == 1'b0) begin
      v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        nib = d[4*i +: 4];
        if (nib > 4'd9) bad = 1'b1;
        v = v * 10 + int'(nib);
      end
      r = DW'(v);
    end else begin
      v = int'(d);
      if (v > (10 ** DIGITS) - 1) bad = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      end
    end
    if (bad) r = '1;
    return {bad, r};
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  // Driver: present one operand, wait for acceptance, push its expected result.
  task automatic send(input logic m, input logic [DW-1:0] d);
    int n;
    n = 0;
    mode = m;
    din = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(ref_model(m, d));
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    #1 in_valid = 1'b0;
  endtask

  // Edges after the accept edge before out_valid becomes visible.
  task automatic wait_valid(output int l);
    l = 0;
    @(negedge clk);
    while (!out_valid && l < 50) begin
      @(negedge clk);
      l++;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got dout=%0h err=%0b expected no output", dout, err);
      end else begin
        exp_e = exp_q.pop_front();
        check("result", 32'({err, dout}), 32'(exp_e));
      end
    end else if (!out_valid) begin
      check("blank_dout", 32'(dout), 32'({DW{1'b1}}));
    end
  end

  // Random backpressure / enable while rnd_en is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        out_ready = ($urandom_range(0, 1) == 1);
        g_n = ($urandom_range(0, 7) == 0);
      end
    end
  end

  initial begin
    logic m;
    logic [DW-1:0] d;
    int v;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dout", 32'(dout), 32'hFF);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Mode 0 latency and 99 -> 0x63
    send(1'b0, 8'h99);
    wait_valid(lat);
    check("lat_bcd2bin", 32'(lat), BIN_W);
    check("dout_99", 32'(dout), 32'h63);
    check("err_99", 32'(err), 0);
    @(posedge clk);
    #1;

    // Mode 0 sweep with throughput
    for (int i = 0; i < 100; i++) begin
      send(1'b0, to_bcd(i));
      if (i > 0) check("throughput_m0", 32'(acc_cyc - prev_acc), BIN_W + 2);
    end

    // Mode 1 directed and sweep
    send(1'b1, 8'h63);
    wait_valid(lat);
    check("lat_bin2bcd", 32'(lat), BIN_W);
    check("dout_63", 32'(dout), 32'h99);
    @(posedge clk);
    #1;
    send(1'b1, 8'h00);
    wait_valid(lat);
    check("dout_0", 32'(dout), 32'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 8'(i));
      if (i > 0) check("throughput_m1", 32'(acc_cyc - prev_acc), BIN_W + 2);
    end

    // Invalid operands: immediate err result
    send(1'b0, 8'h3A);
    wait_valid(lat);
    check("lat_err_bcd", 32'(lat), 0);
    check("err_bcd", 32'(err), 1);
    check("dout_err_bcd", 32'(dout), 32'hFF);
    @(posedge clk);
    #1;
    send(1'b1, 8'd100);
    wait_valid(lat);
    check("lat_err_bin", 32'(lat), 0);
    check("err_bin", 32'(err), 1);
    @(posedge clk);
    #1;
    send(1'b1, 8'h80);
    wait_valid(lat);
    check("err_upper_bit", 32'(err), 1);
    @(posedge clk);
    #1;
    send(1'b0, 8'hA0);
    wait_valid(lat);
    check("err_tens_digit", 32'(err), 1);
    @(posedge clk);
    #1;

    // Backpressure in DONE
    out_ready = 1'b0;
    send(1'b0, 8'h42);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_dout", 32'(dout), 32'h2A);
      check("bp_err", 32'(err), 0);
      check("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 1);
    @(negedge clk);
    check("bp_idle_ready", 32'(in_ready), 1);
    check("bp_idle_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    // g_n high throughout: nothing accepted, output blanked
    g_n = 1'b1;
    in_valid = 1'b1;
    mode = 1'b0;
    din = 8'h12;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("gn_in_ready", 32'(in_ready), 0);
      check("gn_dout", 32'(dout), 32'hFF);
      check("gn_out_valid", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    g_n = 1'b0;

    // g_n pulse during RUN does not stall the conversion
    send(1'b0, 8'h77);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 g_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 g_n = 1'b0;
      end
    join_none
    wait_valid(lat);
    check("gn_run_lat", 32'(lat), BIN_W);
    check("gn_run_dout", 32'(dout), 32'h4D);
    @(posedge clk);
    #1;

    // g_n high in DONE hides the result until it returns low
    out_ready = 1'b0;
    send(1'b1, 8'd57);
    wait_valid(lat);
    @(posedge clk);
    #1 g_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("gn_done_valid", 32'(out_valid), 0);
      check("gn_done_dout", 32'(dout), 32'hFF);
    end
    @(posedge clk);
    #1 g_n = 1'b0;
    @(negedge clk);
    check("gn_done_back_valid", 32'(out_valid), 1);
    check("gn_done_back_dout", 32'(dout), 32'h57);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-RUN discards the conversion
    send(1'b0, 8'h55);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_dout", 32'(dout), 32'hFF);
    check("arst_err", 32'(err), 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_no_output", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure and enable
    rnd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      m = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 255));
      else if (m == 1'b0) d = to_bcd(v);
      else d = 8'(v);
      send(m, d);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    g_n = 1'b0;

    // Drain
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
